// File: rtl/reg_file_pkg.sv
// Shared constants and types for the parametrised register file.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 4;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: one bit per register marking an outstanding load.
// A set and a clear that hit the same register in one cycle leave the bit set.
// The lookups return pre-edge state. With BYPASS, a bit that this edge's write
// is clearing is reported as already clear.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_addr_a,
  input  logic [ADDR_W-1:0] look_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: the write clears first, so a same-cycle set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (busy_set) begin
      busy_d[busy_addr] = 1'b1;
    end
    if (ZERO_R0 != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Per-port lookup, hiding a bit that is being cleared right now when bypassing.
  always_comb begin
    busy_a = busy_q[look_addr_a];
    busy_b = busy_q[look_addr_b];
    if (BYPASS != 0 && clr_en) begin
      if (clr_addr == look_addr_a) begin
        busy_a = 1'b0;
      end
      if (clr_addr == look_addr_b) begin
        busy_b = 1'b0;
      end
    end
  end

  // Busy vector register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule : reg_file_scoreboard

// File: rtl/reg_file_param.sv
// Parametrised architectural register file: one write port, two registered
// read ports, optional write-to-read bypass, optional hardwired-zero R0 and a
// busy scoreboard that flags reads of registers with a pending load.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              hazard
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic              hazard_q, hazard_d;

  logic              busy_a;
  logic              busy_b;

  // Selects what one read port captures: forced zero, bypassed write data, or storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] idx,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (ZERO_R0 != 0 && idx == '0) begin
      val = '0;
    end else if (BYPASS != 0 && wen && waddr == idx) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  reg_file_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .busy_set    (busy_set),
    .busy_addr   (busy_addr),
    .clr_en      (wr_en),
    .clr_addr    (wr_addr),
    .look_addr_a (rd_addr_a),
    .look_addr_b (rd_addr_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b)
  );

  // Storage update; writes to R0 are dropped when R0 is hardwired to zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !(ZERO_R0 != 0 && wr_addr == '0)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read capture: ports load only on rd_en, valid and hazard follow rd_en.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_en) begin
      rd_data_a_d = read_port(rd_addr_a, wr_en, wr_addr, wr_data, mem_q[rd_addr_a]);
      rd_data_b_d = read_port(rd_addr_b, wr_en, wr_addr, wr_data, mem_q[rd_addr_b]);
    end
    rd_valid_d = rd_en;
    hazard_d   = rd_en & (busy_a | busy_b);
  end

  // State registers; reset clears storage and every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      hazard_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
      hazard_q    <= hazard_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign hazard    = hazard_q;

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: a directed vector table against the
// default configuration, plus hand sequences for reset, no-bypass, zero-R0
// and a 32x64 instance.
module tb_reg_file_param;
  import reg_file_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  reg_idx_t    wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  reg_idx_t    rd_addr_a;
  reg_idx_t    rd_addr_b;
  logic        busy_set;
  reg_idx_t    busy_addr;

  logic [31:0] d_a, d_b, nb_a, nb_b, z_a, z_b;
  logic        d_v, d_h, nb_v, nb_h, z_v, z_h;

  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [63:0] w_wr_data;
  logic        w_rd_en;
  logic [4:0]  w_rd_addr_a;
  logic [4:0]  w_rd_addr_b;
  logic        w_busy_set;
  logic [4:0]  w_busy_addr;
  logic [63:0] w_a, w_b;
  logic        w_v, w_h;

  int total;
  int bad;

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(d_a), .rd_data_b(d_b), .rd_valid(d_v),
    .busy_set(busy_set), .busy_addr(busy_addr), .hazard(d_h)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_a), .rd_data_b(nb_b), .rd_valid(nb_v),
    .busy_set(busy_set), .busy_addr(busy_addr), .hazard(nb_h)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_a), .rd_data_b(z_b), .rd_valid(z_v),
    .busy_set(busy_set), .busy_addr(busy_addr), .hazard(z_h)
  );

  reg_file_param #(.DATA_W(64), .ADDR_W(5), .ZERO_R0(0), .BYPASS(1)) dut_w (
    .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_en(w_rd_en), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
    .rd_data_a(w_a), .rd_data_b(w_b), .rd_valid(w_v),
    .busy_set(w_busy_set), .busy_addr(w_busy_addr), .hazard(w_h)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        bs;
    logic [3:0]  ba;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ev;
    logic        eh;
  } vec_t;

  vec_t vecs [13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic rs, input logic we, input logic [3:0] wa, input logic [31:0] wd,
    input logic re, input logic [3:0] ra, input logic [3:0] rb,
    input logic bs, input logic [3:0] ba,
    input logic [31:0] ea, input logic [31:0] eb, input logic ev, input logic eh
  );
    vec_t t;
    t.rst = rs; t.we = we; t.wa = wa; t.wd = wd; t.re = re; t.ra = ra; t.rb = rb;
    t.bs = bs; t.ba = ba; t.ea = ea; t.eb = eb; t.ev = ev; t.eh = eh;
    return t;
  endfunction

  function automatic logic [63:0] wide_pat(input int i);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'hA5A5_0000 | i;
    lo = ~(i * 32'h0101_0107);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0;
    rd_addr_a = '0; rd_addr_b = '0; busy_set = 0; busy_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    rd_en = 1; rd_addr_a = a; rd_addr_b = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    w_wr_en = 0; w_wr_addr = '0; w_wr_data = '0; w_rd_en = 0;
    w_rd_addr_a = '0; w_rd_addr_b = '0; w_busy_set = 0; w_busy_addr = '0;

    //              rst we wa   wd            re ra rb bs ba  exp_a         exp_b         v  h
    vecs[0]  = mk(1, 1, 4'd2, 32'h1, 1, 2, 2, 1, 2, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(0, 1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,  32'h0,        0, 0);
    vecs[2]  = mk(0, 0, 4'd0, 32'h0, 1, 5, 3, 0, 0, 32'hDEADBEEF, 32'h0,        1, 0);
    vecs[3]  = mk(0, 1, 4'd7, 32'h12345678, 1, 7, 5, 0, 0, 32'h12345678, 32'hDEADBEEF, 1, 0);
    vecs[4]  = mk(0, 0, 4'd0, 32'h0, 0, 0, 0, 1, 9, 32'h12345678, 32'hDEADBEEF, 0, 0);
    vecs[5]  = mk(0, 0, 4'd0, 32'h0, 1, 9, 9, 0, 0, 32'h0,        32'h0,        1, 1);
    vecs[6]  = mk(0, 1, 4'd9, 32'hA5, 1, 9, 0, 0, 0, 32'hA5,       32'h0,        1, 0);
    vecs[7]  = mk(0, 0, 4'd0, 32'h0, 1, 9, 5, 0, 0, 32'hA5,       32'hDEADBEEF, 1, 0);
    vecs[8]  = mk(0, 1, 4'd9, 32'h77, 0, 0, 0, 1, 9, 32'hA5,      32'hDEADBEEF, 0, 0);
    vecs[9]  = mk(0, 0, 4'd0, 32'h0, 1, 3, 9, 0, 0, 32'h0,        32'h77,       1, 1);
    vecs[10] = mk(0, 0, 4'd0, 32'h0, 0, 5, 5, 0, 0, 32'h0,        32'h77,       0, 0);
    vecs[11] = mk(0, 0, 4'd0, 32'h0, 1, 3, 3, 1, 3, 32'h0,        32'h0,        1, 0);
    vecs[12] = mk(0, 0, 4'd0, 32'h0, 1, 3, 5, 0, 0, 32'h0,        32'hDEADBEEF, 1, 1);

    rst = 1;
    step();
    step();

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      busy_set = vecs[i].bs; busy_addr = vecs[i].ba;
      step();
      check($sformatf("vec%0d_a", i), 64'(d_a), 64'(vecs[i].ea));
      check($sformatf("vec%0d_b", i), 64'(d_b), 64'(vecs[i].eb));
      check($sformatf("vec%0d_valid", i), 64'(d_v), 64'(vecs[i].ev));
      check($sformatf("vec%0d_hazard", i), 64'(d_h), 64'(vecs[i].eh));
    end

    // Reset in the middle of traffic.
    idle();
    for (int i = 1; i < 16; i++) begin
      do_write(4'(i), 32'h0101_0101 * i);
      step();
    end
    idle();
    busy_set = 1; busy_addr = 4;
    step();
    idle();
    do_read(4, 1);
    step();
    check("pre_rst_hazard", 64'(d_h), 64'h1);
    check("pre_rst_b", 64'(d_b), 64'h0101_0101);
    idle();
    rst = 1; do_write(3, 32'hFFFF_0000); do_read(1, 4); busy_set = 1; busy_addr = 5;
    step();
    check("rst_a", 64'(d_a), 64'h0);
    check("rst_b", 64'(d_b), 64'h0);
    check("rst_valid", 64'(d_v), 64'h0);
    check("rst_hazard", 64'(d_h), 64'h0);
    idle();
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), 4'(15 - i));
      step();
      check($sformatf("postrst%0d_a", i), 64'(d_a), 64'h0);
      check($sformatf("postrst%0d_b", i), 64'(d_b), 64'h0);
      check($sformatf("postrst%0d_hazard", i), 64'(d_h), 64'h0);
      check($sformatf("postrst%0d_valid", i), 64'(d_v), 64'h1);
    end

    // Bypass versus no-bypass on a same-cycle write and read.
    idle();
    do_write(7, 32'h1111_1111); busy_set = 1; busy_addr = 6;
    step();
    idle();
    do_write(7, 32'h1234_5678); do_read(7, 7);
    step();
    check("byp_a", 64'(d_a), 64'h1234_5678);
    check("nobyp_a", 64'(nb_a), 64'h1111_1111);
    check("nobyp_b", 64'(nb_b), 64'h1111_1111);
    idle();
    do_write(6, 32'hBEEF); do_read(6, 7);
    step();
    check("byp_clr_hazard", 64'(d_h), 64'h0);
    check("nobyp_clr_hazard", 64'(nb_h), 64'h1);
    check("byp_a6", 64'(d_a), 64'hBEEF);
    check("nobyp_a6", 64'(nb_a), 64'h0);
    check("nobyp_b7", 64'(nb_b), 64'h1234_5678);
    idle();
    do_read(6, 6);
    step();
    check("nobyp_late_a", 64'(nb_a), 64'hBEEF);
    check("nobyp_late_hazard", 64'(nb_h), 64'h0);

    // Hardwired-zero R0.
    idle();
    do_write(0, 32'hFFFF_FFFF);
    step();
    idle();
    do_read(0, 0);
    step();
    check("z_r0_a", 64'(z_a), 64'h0);
    check("z_r0_b", 64'(z_b), 64'h0);
    check("nz_r0_a", 64'(d_a), 64'hFFFF_FFFF);
    idle();
    busy_set = 1; busy_addr = 0;
    step();
    idle();
    do_read(0, 0);
    step();
    check("z_r0_hazard", 64'(z_h), 64'h0);
    check("z_r0_valid", 64'(z_v), 64'h1);
    check("nz_r0_hazard", 64'(d_h), 64'h1);
    idle();
    do_write(0, 32'h55); do_read(0, 7);
    step();
    check("z_r0_bypass_a", 64'(z_a), 64'h0);
    check("z_r7_b", 64'(z_b), 64'h1234_5678);
    check("nz_r0_bypass_a", 64'(d_a), 64'h55);

    // 32 x 64 instance: fill every register, then read back through both ports.
    idle();
    for (int i = 0; i < 32; i++) begin
      w_wr_en = 1; w_wr_addr = 5'(i); w_wr_data = wide_pat(i);
      step();
    end
    w_wr_en = 0;
    for (int i = 0; i < 32; i++) begin
      w_rd_en = 1; w_rd_addr_a = 5'(i); w_rd_addr_b = 5'(31 - i);
      step();
      check($sformatf("wide%0d_a", i), w_a, wide_pat(i));
      check($sformatf("wide%0d_b", i), w_b, wide_pat(31 - i));
    end
    w_rd_en = 0;
    step();
    check("wide_valid_drop", 64'(w_v), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_param

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the current 16×32 register bank, used as the architectural register file of the datapath. It holds 2^ADDR_W registers of DATA_W bits and provides one write port and two registered read ports. It adds a write enable, synchronous reset, optional write-to-read bypass, and optional hardwired-zero R0. A per-register busy scoreboard flags read hazards against outstanding loads.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register index width; depth = 2^ADDR_W
- ZERO_R0, 0, 1 = register 0 reads as 0, writes to it are discarded, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rd_en  in  1  read strobe; captures both read ports
- rd_addr_a  in  ADDR_W  read index, port A
- rd_addr_b  in  ADDR_W  read index, port B
- rd_data_a  out  DATA_W  registered read data, port A
- rd_data_b  out  DATA_W  registered read data, port B
- rd_valid  out  1  rd_data_* updated by a read in the previous cycle
- busy_set  in  1  mark busy_addr as having a pending load
- busy_addr  in  ADDR_W  register to mark busy
- hazard  out  1  the read returned with rd_valid read a busy register

## Operation
- **Reset.** While rst is high at a clock edge, every register, busy bit, rd_data_a, rd_data_b, rd_valid and hazard is cleared to 0. The rst edge has priority over all other inputs, including wr_en and busy_set in the same cycle.
- **Write.** When wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - With ZERO_R0=1 and wr_addr=0, the write is discarded.
- **Read.** When rd_en=1, each port captures its data:
  - 0 if ZERO_R0=1 and the port index is 0.
  - Otherwise wr_data if BYPASS=1, wr_en=1 and wr_addr equals the port index.
  - Otherwise mem[index] before this edge's write.
  - rd_valid <= rd_en. When rd_en=0, rd_data_* hold their previous value.
- **No bypass.** With BYPASS=0, a same-cycle read of the register being written returns the old value.
- **Scoreboard.**
  - busy_set=1 sets busy[busy_addr]; this is ignored if ZERO_R0=1 and busy_addr=0.
  - If busy_set and a write target the same register in the same cycle, the set wins and the bit ends at 1.
- **Hazard.** hazard <= rd_en & (bA | bB), where bX is the port's busy bit evaluated before this edge's busy_set.
  - With BYPASS=1, a bit being cleared by this edge's write to that register counts as 0.
  - With BYPASS=0, the bit counts at its pre-edge value.
- **Same index on both ports.** rd_addr_a = rd_addr_b is legal; both ports return identical data.

## Timing
- Write-to-storage latency is 1 cycle: a read issued in the cycle after the write returns the new value.
- Read latency is 1 cycle: rd_data_*, rd_valid and hazard are valid the cycle after rd_en.
- Bypass latency is 0 extra cycles: a read in the same cycle as the write returns the new data one cycle later.
- There are no stalls and no backpressure; rd_en is accepted every cycle.
- Reset takes effect at the first rising edge with rst=1.
  - A read captured at that edge is lost: rd_valid=0 on the next cycle.
  - Outputs are 0 from the cycle after that edge onward.

## Structure
- Package reg_file_pkg holds the default DATA_W and ADDR_W constants, plus a reg_idx_t typedef (logic [ADDR_W-1:0] at the default width).
- Sub-module reg_file_scoreboard, written once and instantiated once:
  - Owns the 2^ADDR_W busy vector, the set/clear priority and the ZERO_R0 masking.
  - Exposes the per-port busy lookup for both read indices.
- Top level holds the storage array, the read muxes and bypass compare, and the output registers.

## Test plan
- **Write then read.** Reset; write R5=0xDEADBEEF. Next cycle, read A=5, B=3. One cycle later: rd_data_a=0xDEADBEEF, rd_data_b=0, rd_valid=1, hazard=0.
- **Bypass.** BYPASS=1: write R7=0x12345678 and read A=7 in the same cycle → rd_data_a=0x12345678 next cycle. BYPASS=0: same stimulus → old R7 value.
- **Zero R0.** ZERO_R0=1: write R0=0xFFFFFFFF, then read A=B=0 → both 0; busy_set on R0 followed by a read → hazard=0.
- **Scoreboard.**
  - busy_set R9, then read A=9 → hazard=1.
  - Write R9=0xA5, then read A=9 → hazard=0, data=0xA5.
  - busy_set and write R9 in the same cycle → busy stays 1; the next read gives hazard=1.
- **Reset mid-operation.** Load R1..R15 with nonzero values and set R4 busy. Assert rst for one cycle while wr_en=rd_en=1. Then:
  - The outputs are 0 and rd_valid=0 on the next cycle.
  - Reading any register returns 0 with hazard=0.
- **Wrap/depth.** ADDR_W=5, DATA_W=64: write 2^5 distinct patterns, then read all 32 registers back through both ports → every value matches.
